// File: rtl/wb_block_copier.sv
// Wishbone block copier: word-by-word read/write copy from src to dst.
// Optional ack timeout when WB_COPY_TIMEOUT_EN is defined.
module wb_block_copier #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst_n,
    input  logic [WB_ADDR_WIDTH-1:0] src_adr_i,
    input  logic [WB_ADDR_WIDTH-1:0] dst_adr_i,
    input  logic [LEN_WIDTH-1:0]     len_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic [3:0]               wb_sel_o,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]               r_state;
    logic [WB_ADDR_WIDTH-1:0] r_src;
    logic [WB_ADDR_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]     r_cnt;
    logic [WB_DATA_WIDTH-1:0] r_data;
    logic                     r_err;

    logic w_rd;
    logic w_wr;
    logic w_active;
    logic w_tmo;
    logic w_stop;

    assign w_rd     = (r_state == S_RD);
    assign w_wr     = (r_state == S_WR);
    assign w_active = w_rd | w_wr;

`ifdef WB_COPY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo;

    // an ack in the final allowed cycle still counts as on time
    assign w_tmo = (r_tmo == TW'(TIMEOUT_CYCLES - 1)) && !wb_ack_i;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n || !w_active || wb_ack_i) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_tmo;

    assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
    assign w_tmo        = 1'b0;
`endif

    // abort and bus error both outrank a same-cycle ack
    assign w_stop = w_active & (abort_i | wb_err_i | w_tmo);

    assign wb_cyc_o = w_active;
    assign wb_stb_o = w_active;
    assign wb_we_o  = w_wr;
    assign wb_sel_o = w_active ? 4'hF : 4'h0;
    assign wb_adr_o = w_rd ? r_src : (w_wr ? r_dst : '0);
    assign wb_dat_o = w_wr ? r_data : '0;
    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = (r_state == S_FIN);
    assign err_o    = r_err;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (w_stop) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_src   <= src_adr_i;
                            r_dst   <= dst_adr_i;
                            r_cnt   <= len_i;
                            r_err   <= 1'b0;
                            r_state <= S_RD;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    if (wb_ack_i) begin
                        r_data  <= wb_dat_i;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    if (wb_ack_i) begin
                        r_src   <= r_src + WB_ADDR_WIDTH'(4);
                        r_dst   <= r_dst + WB_ADDR_WIDTH'(4);
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= (r_cnt == LEN_WIDTH'(1)) ? S_FIN : S_RD;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_block_copier.sv
// Scoreboard bench for wb_block_copier with a registered-ack RAM slave.
// Expected writes and done events are queued by stimulus, checked by a monitor.
module tb_wb_block_copier;

    logic        clk;
    logic        rst_n;
    logic [31:0] src_adr;
    logic [31:0] dst_adr;
    logic [15:0] len;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_err;

    wb_block_copier #(
        .WB_DATA_WIDTH (32),
        .WB_ADDR_WIDTH (32),
        .LEN_WIDTH     (16),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .wb_clk   (clk),
        .wb_rst_n (rst_n),
        .src_adr_i(src_adr),
        .dst_adr_i(dst_adr),
        .len_i    (len),
        .start_i  (start),
        .abort_i  (abort),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we),
        .wb_cyc_o (wb_cyc),
        .wb_stb_o (wb_stb),
        .wb_sel_o (wb_sel),
        .wb_ack_i (wb_ack),
        .wb_err_i (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycnt    = 0;
    int t0       = 0;
    int wr_seen  = 0;
    int busy_cnt = 0;
    bit cyc_seen = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        logic err;
        int   lat;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];

    logic [31:0] mem [1024];
    logic        noack  = 1'b0;
    int          err_rd = -1;
    int          rd_cnt;
    logic        pl_en  = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    assign wb_dat_i = mem[wb_adr[11:2]];

    always @(posedge clk) cycnt <= cycnt + 1;

    // registered-ack RAM slave with optional error on the Nth read
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_dat;
        if (!rst_n) begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            rd_cnt <= 0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            if (wb_cyc && wb_stb && !wb_ack && !wb_err && !noack) begin
                if (!wb_we && rd_cnt == err_rd) wb_err <= 1'b1;
                else wb_ack <= 1'b1;
            end
            if (wb_cyc && wb_stb && wb_ack && !wb_we) rd_cnt <= rd_cnt + 1;
            if (wb_cyc && wb_stb && wb_ack && wb_we)
                mem[wb_adr[11:2]] <= wb_dat_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (wb_cyc) cyc_seen = 1;
            if (wb_cyc && wb_stb && wb_we && wb_ack) begin
                wr_seen++;
                if (wq.size() == 0) begin
                    chk("unexpected_write", wb_adr, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_adr", wb_adr, w.adr);
                    chk("wr_dat", wb_dat_o, w.dat);
                    chk("wr_sel", {28'd0, wb_sel}, 32'hF);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("done_err", {31'd0, err}, {31'd0, d.err});
                    if (d.lat >= 0)
                        chk("done_lat", cycnt - t0, d.lat);
                end
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx[9:0];
        pl_dat = d;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.adr = a;
        w.dat = d;
        wq.push_back(w);
    endtask

    task automatic exp_done(input logic e, input int lat);
        done_t d;
        d.err = e;
        d.lat = lat;
        dq.push_back(d);
    endtask

    task automatic copy(input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] n);
        @(negedge clk);
        src_adr = s;
        dst_adr = d;
        len     = n;
        start   = 1'b1;
        t0      = cycnt;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({nm, "_timeout"}, 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_cyc"}, {31'd0, wb_cyc}, 32'd0);
        chk({nm, "_stb"}, {31'd0, wb_stb}, 32'd0);
        chk({nm, "_we"}, {31'd0, wb_we}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_err"}, {31'd0, err}, 32'd0);
        chk({nm, "_adr"}, wb_adr, 32'd0);
        chk({nm, "_dato"}, wb_dat_o, 32'd0);
        chk({nm, "_sel"}, {28'd0, wb_sel}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        src_adr = '0;
        dst_adr = '0;
        len     = '0;
        start   = 1'b0;
        abort   = 1'b0;
        preload(64, 32'hA0);
        preload(65, 32'hA1);
        preload(66, 32'hA2);
        preload(1023, 32'h1111_1111);
        preload(0, 32'h2222_2222);
        preload(322, 32'hDEAD_0000);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // basic 3-word copy
        exp_wr(32'h200, 32'hA0);
        exp_wr(32'h204, 32'hA1);
        exp_wr(32'h208, 32'hA2);
        exp_done(1'b0, 13);
        copy(32'h100, 32'h200, 16'd3);
        wait_idle("copy3");
        chk("mem_200", mem[128], 32'hA0);
        chk("mem_204", mem[129], 32'hA1);
        chk("mem_208", mem[130], 32'hA2);

        // zero length
        busy_cnt = 0;
        cyc_seen = 0;
        exp_done(1'b0, 1);
        copy(32'h100, 32'h300, 16'd0);
        wait_idle("len0");
        chk("len0_busy_cycles", busy_cnt, 32'd1);
        chk("len0_cyc_seen", {31'd0, cyc_seen}, 32'd0);

        // bus error on the second read
        err_rd = rd_cnt + 1;
        exp_wr(32'h700, 32'hA0);
        exp_done(1'b1, 7);
        copy(32'h100, 32'h700, 16'd4);
        wait_idle("rderr");
        chk("rderr_err_sticky", {31'd0, err}, 32'd1);
        err_rd = -1;

        // source address wraps past the top of the map
        exp_wr(32'h400, 32'h1111_1111);
        exp_wr(32'h404, 32'h2222_2222);
        exp_done(1'b0, 9);
        copy(32'hFFFF_FFFC, 32'h400, 16'd2);
        wait_idle("wrap");

        // abort during the third write, start ignored while busy
        exp_wr(32'h500, 32'hA0);
        exp_wr(32'h504, 32'hA1);
        exp_done(1'b1, -1);
        wr_seen = 0;
        copy(32'h100, 32'h500, 16'd8);
        copy(32'h0, 32'h600, 16'd1);
        begin
            int n;
            n = 0;
            while (!(wb_we && wr_seen == 2) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("abort_reached_wr3", {31'd0, wb_we && wr_seen == 2}, 32'd1);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_cyc_low", {31'd0, wb_cyc}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd1);
        wait_idle("abort");
        chk("abort_mem_untouched", mem[322], 32'hDEAD_0000);

        // slave that never acks
        noack = 1'b1;
`ifdef WB_COPY_TIMEOUT_EN
        exp_done(1'b1, 11);
        copy(32'h100, 32'h300, 16'd1);
        wait_idle("tmo");
        chk("tmo_err", {31'd0, err}, 32'd1);
`else
        copy(32'h100, 32'h300, 16'd1);
        repeat (50) @(negedge clk);
        chk("noack_cyc_held", {31'd0, wb_cyc}, 32'd1);
        chk("noack_busy_held", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("noack_reset_cyc", {31'd0, wb_cyc}, 32'd0);
`endif
        noack = 1'b0;

        // reset in the middle of a write
        copy(32'h100, 32'h800, 16'd2);
        begin
            int n;
            n = 0;
            while (!wb_we && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("midwr_reached", {31'd0, wb_we}, 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midwr_rst");
        rst_n = 1'b1;
        @(negedge clk);

        exp_wr(32'h900, 32'hA1);
        exp_wr(32'h904, 32'hA2);
        exp_done(1'b0, 9);
        copy(32'h104, 32'h900, 16'd2);
        wait_idle("postrst");
        chk("postrst_mem_900", mem[576], 32'hA1);
        chk("postrst_mem_904", mem[577], 32'hA2);

        chk("wq_drained", wq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_block_copier.md
WB_BLOCK_COPIER -- requirements
Module: wb_block_copier

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, data bus width (32 only).
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the word-count field.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ack wait (used only with WB_COPY_TIMEOUT_EN).
REQ-005 SHALL have port wb_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port wb_rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports src_adr_i / dst_adr_i  in  WB_ADDR_WIDTH  source and destination byte addresses (word-aligned).
REQ-008 SHALL have port len_i  in  LEN_WIDTH  number of 32-bit words to copy.
REQ-009 SHALL have port start_i  in  1  one-cycle start request.
REQ-010 SHALL have port abort_i  in  1  terminate the transfer in progress.
REQ-011 SHALL have ports busy_o / done_o / err_o  out  1  busy level; one-cycle completion pulse; sticky error flag.
REQ-012 SHALL have ports wb_adr_o  out  WB_ADDR_WIDTH; wb_dat_o  out  32; wb_dat_i  in  32; wb_we_o, wb_cyc_o, wb_stb_o  out  1; wb_sel_o  out  4; wb_ack_i, wb_err_i  in  1 (Wishbone initiator).

Function
REQ-013 SHALL implement states IDLE, RD, WR, FIN.
REQ-014 IDLE: start_i=1 with len_i!=0 SHALL latch src, dst and len, clear err_o, and enter RD; len_i=0 SHALL go directly to FIN with no bus cycle.
REQ-015 start_i SHALL be ignored outside IDLE.
REQ-016 RD: cyc=1, stb=1, we=0, sel=4'hF, adr=current src; on wb_ack_i, latch wb_dat_i into the data register and go to WR.
REQ-017 WR: cyc=1, stb=1, we=1, sel=4'hF, adr=current dst, dat_o=data register; on wb_ack_i, add 4 to src and dst, decrement the count, and go to RD if the count is nonzero, else FIN.
REQ-018 stb SHALL remain asserted from the cycle after start through the final ack; the target's registered ack (one cycle after stb) gives 4 cycles per word.
REQ-019 cyc_o SHALL stay high continuously across RD/WR of one transfer; cyc_o and stb_o SHALL be low in IDLE and FIN.
REQ-020 FIN: done_o=1 for exactly one cycle, then IDLE; busy_o=1 in RD, WR and FIN.
REQ-021 wb_err_i in RD or WR SHALL set err_o and go to FIN, with no address or count update.
REQ-022 abort_i in RD or WR SHALL set err_o and go to FIN on the next edge, dropping cyc/stb; an ack arriving in the same cycle SHALL be discarded.
REQ-023 Address increments SHALL wrap modulo 2^WB_ADDR_WIDTH.
REQ-024 Simultaneous ack and err SHALL be treated as err.

Reset
REQ-025 wb_rst_n=0 at a clock edge SHALL force IDLE, with cyc, stb, we, busy, done and err at 0, adr, dat_o and count at 0, and sel at 0, regardless of state; a cycle in progress SHALL be dropped.

Configuration
REQ-026 Macro WB_COPY_TIMEOUT_EN defined: a counter cleared on entry to RD/WR SHALL abort as in REQ-021 when TIMEOUT_CYCLES cycles pass without ack.
REQ-027 WB_COPY_TIMEOUT_EN undefined: no counter SHALL be present and the block SHALL wait indefinitely for ack/err.

Verification
REQ-028 src=0x100, dst=0x200, len=3, one-cycle-ack RAM preloaded 0xA0..0xA2 -> 0x200..0x208 hold 0xA0..0xA2; done pulses at cycle 13 after start; err_o=0.
REQ-029 len=0, start -> done at cycle 1, cyc_o never high, busy high for 1 cycle.
REQ-030 len=4, wb_err_i on second read -> err_o=1, done pulses, only word 0 written.
REQ-031 len=8, abort_i during the third write -> cyc_o low the next cycle, err_o=1, 2 words written; start ignored while busy.
REQ-032 WB_COPY_TIMEOUT_EN with TIMEOUT_CYCLES=10 and a slave that never acks -> err_o=1 after 10 cycles; without the macro, cyc_o remains high indefinitely.
REQ-033 wb_rst_n=0 mid-WR -> next cycle all outputs 0 and state IDLE; a new start then copies correctly.
